serial_subtractor: RTL and testbench

Parametrised multi-cycle unsigned subtractor computing Diff = A − B with a Borrow output. Each cycle it processes DIGIT bits, least-significant digit first, through a ripple chain of 1-bit full-subtractor cells. It extends the team's combinational half/full subtractor cells into a sequential datapath unit with a start/busy/done handshake, trading latency for area in arithmetic pipelines.

---
 rtl/serial_sub_pkg.sv | 21 ++
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StNeg,
    StDone
  } state_e;

  // Ceiling log2, used to size the digit counter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: Diff = A - B - Bin with borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor, LSB digit first, with start/busy/done handshake.
// Define SERIAL_SUB_ABS_EN to add a NEG state so Diff reports |A - B|.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = clog2(NDIG + 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_subtractor: illegal WIDTH/DIGIT combination");
  end

  state_e           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             bq;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] dig_diff;
  logic [WIDTH-1:0] r_next;
  logic             last;

  assign chain[0] = bq;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_subtractor u_fs (
      .A   (a_sr[i]),
      .B   (b_sr[i]),
      .Bin (chain[i]),
      .Diff(dig_diff[i]),
      .Bout(chain[i+1])
    );
  end

  // New digit enters at the MSB end; after NDIG shifts r_sr holds the full result.
  assign r_next = (r_sr >> DIGIT) | (WIDTH'(dig_diff) << (WIDTH - DIGIT));
  assign last   = (cnt == CW'(NDIG - 1));

`ifdef SERIAL_SUB_ABS_EN
  logic [WIDTH-1:0] r_neg;
  assign r_neg = ~r_sr + WIDTH'(1);
`endif

  assign busy = (state != StIdle);
  assign done = (state == StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= StIdle;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      bq     <= 1'b0;
      cnt    <= '0;
      Diff   <= '0;
      Borrow <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            bq    <= 1'b0;
            cnt   <= '0;
            state <= StRun;
          end
        end
        StRun: begin
          a_sr <= a_sr >> DIGIT;
          b_sr <= b_sr >> DIGIT;
          r_sr <= r_next;
          bq   <= chain[DIGIT];
          cnt  <= cnt + 1'b1;
          if (last) begin
`ifdef SERIAL_SUB_ABS_EN
            state <= StNeg;
`else
            // Outputs load on the edge entering DONE so they are valid with done.
            Diff   <= r_next;
            Borrow <= chain[DIGIT];
            state  <= StDone;
`endif
          end
        end
`ifdef SERIAL_SUB_ABS_EN
        StNeg: begin
          if (bq) r_sr <= r_neg;
          Diff   <= bq ? r_neg : r_sr;
          Borrow <= bq;
          state  <= StDone;
        end
`endif
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: four 8-bit instances with DIGIT = 1, 2, 4, 8 run in lockstep.
module tb_serial_subtractor;

`ifdef SERIAL_SUB_ABS_EN
  localparam int AbsEn = 1;
`else
  localparam int AbsEn = 0;
`endif
  localparam int NInst = 4;
  localparam int MaxK  = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;

  logic [7:0] diff   [NInst];
  logic       borrow [NInst];
  logic       busy   [NInst];
  logic       done   [NInst];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    serial_subtractor #(
      .WIDTH(8),
      .DIGIT(1 << g)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (a_in),
      .B     (b_in),
      .Diff  (diff[g]),
      .Borrow(borrow[g]),
      .busy  (busy[g]),
      .done  (done[g])
    );
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] wrap_d;
    logic [7:0] abs_d;
    logic       bor;
  } vec_t;

  function automatic int latency(input int g);
    return 8 / (1 << g) + AbsEn;
  endfunction

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [8:0] ref_sub(input int a, input int b);
    int d;
    int m;
    d = a - b;
    if (AbsEn != 0) m = (d < 0) ? -d : d;
    else m = (d + 256) % 256;
    return {logic'(a < b), m[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    for (int g = 0; g < NInst; g++) begin
      check($sformatf("%s busy d%0d", tag, 1 << g), 32'(busy[g]), 32'd0);
      check($sformatf("%s done d%0d", tag, 1 << g), 32'(done[g]), 32'd0);
      check($sformatf("%s diff d%0d", tag, 1 << g), 32'(diff[g]), 32'd0);
      check($sformatf("%s borrow d%0d", tag, 1 << g), 32'(borrow[g]), 32'd0);
    end
  endtask

  // Starts one operation and follows all instances for MaxK edges.
  // inject_k >= 0 raises start with other operands during that cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                        input logic eb, input int inject_k, input string tag);
    int first  [NInst];
    int pulses [NInst];
    for (int g = 0; g < NInst; g++) begin
      first[g]  = -1;
      pulses[g] = 0;
      check($sformatf("%s idle busy d%0d", tag, 1 << g), 32'(busy[g]), 32'd0);
    end
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= MaxK; k++) begin
      for (int g = 0; g < NInst; g++) begin
        if (done[g]) begin
          pulses[g]++;
          if (first[g] < 0) first[g] = k;
        end
        check($sformatf("%s busy d%0d k%0d", tag, 1 << g, k), 32'(busy[g]),
              32'(k <= latency(g)));
        if (k >= latency(g)) begin
          check($sformatf("%s diff d%0d k%0d", tag, 1 << g, k), 32'(diff[g]), 32'(ed));
          check($sformatf("%s borrow d%0d k%0d", tag, 1 << g, k), 32'(borrow[g]), 32'(eb));
        end
      end
      if (k == inject_k) begin
        a_in  = ~a;
        b_in  = ~b;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    for (int g = 0; g < NInst; g++) begin
      check($sformatf("%s done pulses d%0d", tag, 1 << g), 32'(pulses[g]), 32'd1);
      check($sformatf("%s latency d%0d", tag, 1 << g), 32'(first[g]), 32'(latency(g)));
    end
  endtask

  initial begin
    vec_t vecs [5];
    logic [8:0] r;
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, wrap_d: 8'h1E, abs_d: 8'h1E, bor: 1'b0};
    vecs[1] = '{a: 8'h03, b: 8'h05, wrap_d: 8'hFE, abs_d: 8'h02, bor: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'h01, wrap_d: 8'hFF, abs_d: 8'h01, bor: 1'b1};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, wrap_d: 8'h00, abs_d: 8'h00, bor: 1'b0};
    vecs[4] = '{a: 8'h00, b: 8'hFF, wrap_d: 8'h01, abs_d: 8'hFF, bor: 1'b1};

    rst = 1'b1;
    step();
    step();
    check_zero("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, (AbsEn != 0) ? vecs[i].abs_d : vecs[i].wrap_d,
             vecs[i].bor, -1, $sformatf("vec%0d", i));
    end

    // Second start while busy must be dropped.
    run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1, "ignore_start");

    // Synchronous reset in the middle of a DIGIT=1 run (cnt = 3).
    a_in  = 8'h77;
    b_in  = 8'h99;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check_zero("mid_reset");
    rst = 1'b0;
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, -1, "after_reset");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      r  = ref_sub(int'(ra), int'(rb));
      run_op(ra, rb, r[7:0], r[8], -1, $sformatf("rand%0d a%0h b%0h", i, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
